// File: rtl/onehot_encoder_buf.sv
// One-hot to binary encoder with legality flags, followed by a 2-entry
// valid/ready output buffer and a saturating count of illegal words.
module onehot_encoder_buf #(
   parameter int N     = 16,
   parameter int W     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [W-1:0]     out,
   output logic             out_ok,
   output logic             out_zero,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             clear_err,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state;

   logic         accept;
   logic         pop;

   logic [W-1:0] enc_idx_p0;
   logic         enc_ok_p0;
   logic         enc_zero_p0;

   logic [W-1:0] head_idx_p1;
   logic         head_ok_p1;
   logic         head_zero_p1;
   logic [W-1:0] tail_idx_p1;
   logic         tail_ok_p1;
   logic         tail_zero_p1;

   // Lowest set bit wins; scanning from the top lets later (lower) hits overwrite.
   function automatic logic [W-1:0] lsb_index(input logic [N-1:0] word);
      logic [W-1:0] idx;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (word[i]) idx = W'(i);
      end
      return idx;
   endfunction

   function automatic logic is_one_hot(input logic [N-1:0] word);
      return (word != '0) && ((word & (word - N'(1))) == '0);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + CNT_W'(1);
   endfunction

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Stage p0: combinational encode of the offered word
   assign enc_idx_p0  = lsb_index(in);
   assign enc_ok_p0   = is_one_hot(in);
   assign enc_zero_p0 = (in == '0);

   // Stage p1: buffer state and head entry; head is zeroed whenever it empties
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= EMPTY;
         head_idx_p1  <= '0;
         head_ok_p1   <= 1'b0;
         head_zero_p1 <= 1'b0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  state        <= ONE;
                  head_idx_p1  <= enc_idx_p0;
                  head_ok_p1   <= enc_ok_p0;
                  head_zero_p1 <= enc_zero_p0;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  head_idx_p1  <= enc_idx_p0;
                  head_ok_p1   <= enc_ok_p0;
                  head_zero_p1 <= enc_zero_p0;
               end else if (accept) begin
                  state <= FULL;
               end else if (pop) begin
                  state        <= EMPTY;
                  head_idx_p1  <= '0;
                  head_ok_p1   <= 1'b0;
                  head_zero_p1 <= 1'b0;
               end
            end
            FULL: begin
               if (pop) begin
                  state        <= ONE;
                  head_idx_p1  <= tail_idx_p1;
                  head_ok_p1   <= tail_ok_p1;
                  head_zero_p1 <= tail_zero_p1;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   // Tail only matters while FULL, so it is neither reset nor cleared on pop.
   always_ff @(posedge clk) begin
      if (accept && (state == ONE) && !pop) begin
         tail_idx_p1  <= enc_idx_p0;
         tail_ok_p1   <= enc_ok_p0;
         tail_zero_p1 <= enc_zero_p0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
      end else if (clear_err) begin
         err_count <= '0;
      end else if (accept && !enc_ok_p0) begin
         err_count <= sat_inc(err_count);
      end
   end

   assign out      = head_idx_p1;
   assign out_ok   = head_ok_p1;
   assign out_zero = head_zero_p1;

endmodule

// File: tb/tb_onehot_encoder_buf.sv
// Scoreboard bench for onehot_encoder_buf, built with a 2-bit error counter
// so saturation is reachable.
module tb_onehot_encoder_buf;

   localparam int N     = 16;
   localparam int W     = 4;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     in_w = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     out;
   logic             out_ok;
   logic             out_zero;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             clear_err = 1'b0;
   logic [CNT_W-1:0] err_count;

   int total = 0;
   int bad   = 0;
   logic [5:0] exp_q[$];
   int exp_err = 0;

   onehot_encoder_buf #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in(in_w), .in_valid(in_valid), .in_ready(in_ready),
      .out(out), .out_ok(out_ok), .out_zero(out_zero), .out_valid(out_valid),
      .out_ready(out_ready), .clear_err(clear_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Reference encoding {index, ok, zero} via isolated lowest bit.
   function automatic logic [5:0] ref_enc(input logic [15:0] w);
      logic [15:0] low;
      logic [3:0]  idx;
      low = w & (~w + 16'd1);
      idx = (w == 16'd0) ? 4'd0 : 4'($clog2(low));
      return {idx, ($countones(w) == 1), (w == 16'd0)};
   endfunction

   // Scoreboard: inputs are stable at the falling edge, so handshakes seen
   // here are the ones the next rising edge will perform.
   always @(negedge clk) begin
      logic [5:0] e;
      logic [5:0] en;
      if (!rst) begin
         en = ref_enc(in_w);
         if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_extra: out=%0d popped with no word expected", out);
            end else begin
               e = exp_q.pop_front();
               if ({out, out_ok, out_zero} !== e) begin
                  bad++;
                  $display("FAIL sb_data: out=%0d ok=%0b zero=%0b expected out=%0d ok=%0b zero=%0b",
                           out, out_ok, out_zero, e[5:2], e[1], e[0]);
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(en);
         if (clear_err) exp_err = 0;
         else if (in_valid && in_ready && !en[1] && exp_err != 3) exp_err++;
      end
   end

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clear_err = 1'b0; in_w = '0;
      exp_q.delete(); exp_err = 0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({out_valid, out, out_ok, out_zero} !== 7'd0) begin
         bad++;
         $display("FAIL reset_out: valid=%0b out=%0d ok=%0b zero=%0b expected all 0",
                  out_valid, out, out_ok, out_zero);
      end
      total++;
      if (err_count !== 2'd0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ctl: err=%0d in_ready=%0b expected 0 and 1", err_count, in_ready);
      end
      @(posedge clk); #2; rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release: valid=%0b in_ready=%0b expected 0 and 1", out_valid, in_ready);
      end
   endtask

   task automatic test_sweep();
      @(posedge clk); #2; out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         in_w = 16'h0001 << k; in_valid = 1'b1;
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b1 || out !== 4'(k) || out_ok !== 1'b1 || out_zero !== 1'b0) begin
            bad++;
            $display("FAIL sweep_out: k=%0d valid=%0b out=%0d ok=%0b zero=%0b expected 1 %0d 1 0",
                     k, out_valid, out, out_ok, out_zero, k);
         end
         total++;
         if (in_ready !== 1'b1 || err_count !== 2'd0) begin
            bad++;
            $display("FAIL sweep_ctl: k=%0d in_ready=%0b err=%0d expected 1 and 0", k, in_ready, err_count);
         end
         #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || out !== 4'd0) begin
         bad++;
         $display("FAIL sweep_drain: valid=%0b out=%0d expected 0 0", out_valid, out);
      end
   endtask

   task automatic test_backpressure();
      @(posedge clk); #2; out_ready = 1'b0; in_valid = 1'b1; in_w = 16'h0004;
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out !== 4'd2) begin
         bad++;
         $display("FAIL bp_first: in_ready=%0b valid=%0b out=%0d expected 1 1 2", in_ready, out_valid, out);
      end
      #1; in_w = 16'h0100;
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b0 || out !== 4'd2) begin
         bad++;
         $display("FAIL bp_full: in_ready=%0b out=%0d expected 0 2", in_ready, out);
      end
      #1; in_w = 16'h8000;
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b0 || out !== 4'd2 || out_ok !== 1'b1 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL bp_hold: in_ready=%0b out=%0d ok=%0b valid=%0b expected 0 2 1 1",
                  in_ready, out, out_ok, out_valid);
      end
      #1; out_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if (out !== 4'd8 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_second: out=%0d in_ready=%0b expected 8 1", out, in_ready);
      end
      @(posedge clk); #1;
      total++;
      if (out !== 4'd15 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL bp_third: out=%0d valid=%0b expected 15 1", out, out_valid);
      end
      #1; in_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL bp_drain: valid=%0b pending=%0d expected 0 0", out_valid, exp_q.size());
      end
   endtask

   task automatic test_illegal();
      test_reset();
      @(posedge clk); #2; out_ready = 1'b1; in_valid = 1'b1; in_w = 16'h0000;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out !== 4'd0 || out_zero !== 1'b1 || out_ok !== 1'b0) begin
         bad++;
         $display("FAIL ill_zero: valid=%0b out=%0d zero=%0b ok=%0b expected 1 0 1 0",
                  out_valid, out, out_zero, out_ok);
      end
      #1; in_w = 16'h0030;
      @(posedge clk); #1;
      total++;
      if (out !== 4'd4 || out_ok !== 1'b0 || out_zero !== 1'b0) begin
         bad++;
         $display("FAIL ill_multi: out=%0d ok=%0b zero=%0b expected 4 0 0", out, out_ok, out_zero);
      end
      #1; in_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (err_count !== 2'd2 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL ill_count: err=%0d valid=%0b expected 2 0", err_count, out_valid);
      end
   endtask

   task automatic test_saturation();
      int sat_exp[5] = '{1, 2, 3, 3, 3};
      test_reset();
      @(posedge clk); #2; out_ready = 1'b1; in_valid = 1'b1; in_w = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if (err_count !== 2'(sat_exp[i]) || err_count !== 2'(exp_err)) begin
            bad++;
            $display("FAIL sat_count: step=%0d err=%0d expected %0d", i, err_count, sat_exp[i]);
         end
         #1;
      end
      clear_err = 1'b1;
      @(posedge clk); #1;
      total++;
      if (err_count !== 2'd0) begin
         bad++;
         $display("FAIL sat_clear: err=%0d expected 0", err_count);
      end
      #1; clear_err = 1'b0; in_valid = 1'b0;
      @(posedge clk);
   endtask

   task automatic test_async_reset();
      @(posedge clk); #2; out_ready = 1'b0; in_valid = 1'b1; in_w = 16'h0000;
      @(posedge clk); #2; in_w = 16'h0200;
      @(posedge clk); #2; in_valid = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b0 || err_count !== 2'd1) begin
         bad++;
         $display("FAIL arst_fill: in_ready=%0b err=%0d expected 0 1", in_ready, err_count);
      end
      #1; rst = 1'b1;
      #1;
      exp_q.delete(); exp_err = 0;
      total++;
      if ({out_valid, out, out_ok, out_zero} !== 7'd0 || err_count !== 2'd0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL arst_now: valid=%0b out=%0d ok=%0b zero=%0b err=%0d in_ready=%0b expected 0 0 0 0 0 1",
                  out_valid, out, out_ok, out_zero, err_count, in_ready);
      end
      @(posedge clk); #2; rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL arst_stale: cycle=%0d valid=%0b out=%0d expected valid 0", i, out_valid, out);
         end
      end
   endtask

   task automatic test_random();
      int acc_n = 0;
      int cyc = 0;
      logic stall = 1'b0;
      logic [5:0] held = '0;
      while (acc_n < 1000 && cyc < 20000) begin
         @(posedge clk); #1; cyc++;
         if (stall) begin
            total++;
            if (out_valid !== 1'b1 || {out, out_ok, out_zero} !== held) begin
               bad++;
               $display("FAIL rand_stable: valid=%0b out=%0d ok=%0b zero=%0b expected 1 %0d %0b %0b",
                        out_valid, out, out_ok, out_zero, held[5:2], held[1], held[0]);
            end
         end
         total++;
         if (err_count !== 2'(exp_err)) begin
            bad++;
            $display("FAIL rand_err: err=%0d expected %0d", err_count, exp_err);
         end
         #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         clear_err = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 9) < 8) in_w = 16'h0001 << $urandom_range(0, 15);
         else in_w = 16'($urandom);
         if (in_valid && in_ready) acc_n++;
         stall = out_valid && !out_ready;
         held  = {out, out_ok, out_zero};
      end
      total++;
      if (acc_n < 1000) begin
         bad++;
         $display("FAIL rand_timeout: accepted=%0d expected 1000", acc_n);
      end
      in_valid = 1'b0; out_ready = 1'b1; clear_err = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rand_drain: pending=%0d valid=%0b expected 0 0", exp_q.size(), out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_backpressure();
      test_illegal();
      test_saturation();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/onehot_encoder_buf.md
Name: onehot_encoder_buf

Overview:
Binary-recovery counterpart of the 4-to-16 one-hot decoder. It accepts 16-bit one-hot words over a valid/ready handshake and encodes each one to a 4-bit binary index. Each word is checked for one-hot legality, and the result goes into a 2-entry output buffer with its own valid/ready handshake. It sits downstream of decoded select buses and returns them to binary form for the rest of the converter datapath.

Parameters:
N, 16, input word width (one-hot lanes); must be a power of 2, at least 2
W, 4, output index width; must equal log2(N)
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in  input  N  one-hot word to encode
in_valid  input  1  in holds a word this cycle
in_ready  output  1  block can accept a word this cycle
out  output  W  encoded index of the head entry
out_ok  output  1  head word had exactly one bit set
out_zero  output  1  head word was all zeros
out_valid  output  1  head entry is valid
out_ready  input  1  consumer takes the head entry this cycle
clear_err  input  1  synchronous clear of err_count
err_count  output  CNT_W  count of accepted non-one-hot words

Behaviour:
- Reset (async assert, sync release): buffer EMPTY; out_valid=0; out=0; out_ok=0; out_zero=0; err_count=0; in_ready=1.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Pop occurs when out_valid && out_ready.
  - in_ready depends only on registered state (in_ready = state!=FULL). It has no combinational path from out_ready.
  - out, out_ok and out_zero stay stable while out_valid=1 and out_ready=0.
- Encoding (combinational on in, captured on accept):
  - Index = position of the lowest set bit (LSB priority).
  - out_ok = popcount(in)==1.
  - out_zero = (in==0); a zero word gives index 0.
  - Multiple set bits give the lowest index with out_ok=0.
  - Any legal one-hot word round-trips exactly through the decoder.
- Latency: an accepted word is visible on out_valid the next cycle at the earliest. Throughput is one word per cycle when out_ready is held high.
- Buffer FSM (states EMPTY, ONE, FULL):
  - EMPTY: accept -> ONE (word becomes head). No accept -> stay EMPTY.
  - ONE, accept and pop -> stay ONE; new word becomes head the same edge.
  - ONE, accept only -> FULL; new word goes to tail.
  - ONE, pop only -> EMPTY.
  - ONE, neither -> stay ONE.
  - FULL: in_ready=0, so in_valid is ignored. Pop -> ONE (tail moves to head). No pop -> stay FULL.
- Order: words leave strictly in acceptance order; none is dropped or duplicated.
- err_count:
  - Increments by 1 on each accepted word with out_ok=0 (zero or multi-hot).
  - Saturates at 2^CNT_W-1 with no wrap.
  - clear_err=1 sets it to 0 on the next edge. clear_err takes priority over a same-cycle increment, so the result is 0.
  - Counting happens at accept time, independent of the output handshake.
- Reset mid-operation: buffered entries are discarded immediately and all outputs return to reset values asynchronously.
- Payload registers: the tail entry need not be cleared on pop. The head payload must read 0 whenever out_valid=0.

Test Plan:
- Reset then sweep in=16'h0001<<k for k=0..15, in_valid=1, out_ready=1 -> out=k one cycle after each accept, out_ok=1, err_count stays 0, in_ready held at 1.
- Backpressure: out_ready=0, offer 16'h0004, 16'h0100, 16'h8000 -> first two accepted; in_ready=0 from the cycle after the second accept; third held off. Then out_ready=1 -> outputs 2, 8, 15 in that order, third accepted once in_ready returns to 1.
- Illegal words 16'h0000 and 16'h0030 -> first gives out=0, out_zero=1, out_ok=0. Second gives out=4, out_ok=0, out_zero=0. err_count=2.
- Saturation with CNT_W=2: accept 5 zero words -> err_count = 1, 2, 3, 3, 3. Assert clear_err in the same cycle as a further zero-word accept -> err_count=0.
- FULL then assert rst asynchronously mid-cycle -> out_valid=0, out=0, err_count=0 and in_ready=1 immediately. No stale words appear after release.
- Random traffic of 1000 words with random in_valid/out_ready -> output sequence matches a reference queue of LSB-priority encodings, and out stays stable while stalled.
